isqrt_seq: RTL
==============

ISQRT_SEQ -- requirements
Module: isqrt_seq

Interface
REQ-001 The block SHALL have parameter RES_W, default 32: result width; the operand is 2*RES_W bits; legal range 4..32.
REQ-002 The block SHALL have parameter MULT_LAT, default 8: internal squaring-multiplier pipeline latency in cycles; legal range 1..16.
REQ-003 Port clock, input, 1: single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1: asynchronous active-low reset; 0 SHALL immediately clear all state, and release SHALL be synchronous to clock.
REQ-005 Port start, input, 1: request pulse; sampled on the rising edge.
REQ-006 Port value, input, 2*RES_W: operand; captured only on an accepted start.
REQ-007 Port result, output, RES_W: largest r with r*r <= captured value.
REQ-008 Port done, output, 1: one-cycle pulse; result valid from this cycle.
REQ-009 Port busy, output, 1: high while a computation is in progress, i.e. in any state other than IDLE and DONE.

Function
REQ-010 The block SHALL contain its own MULT_LAT-stage pipelined RES_W x RES_W unsigned multiplier with a 2*RES_W-bit product, squaring the current guess.
REQ-011 The FSM SHALL have exactly these states: IDLE, ISSUE, WAIT, CHECK, DONE.
REQ-012 In IDLE, DONE or any busy state, start=1 SHALL be accepted:
- capture value;
- clear the working result to 0;
- set the bit index to RES_W-1;
- go to ISSUE.
REQ-013 In ISSUE (1 cycle), the guess (working result OR 1<<index) SHALL be presented to the multiplier, then the FSM SHALL go to WAIT.
REQ-014 In WAIT (MULT_LAT-1 cycles, counted by an internal counter), the FSM SHALL go to CHECK once the product is valid.
REQ-015 In CHECK (1 cycle), if product <= captured value, the index bit SHALL be set in the working result; otherwise it SHALL stay 0.
REQ-016 After CHECK, if index=0 the FSM SHALL go to DONE; otherwise the index SHALL decrement and the FSM SHALL go to ISSUE.
REQ-017 Each bit SHALL take exactly MULT_LAT+1 cycles (ISSUE + WAIT + CHECK).
REQ-018 In DONE (1 cycle), done=1 and result SHALL be updated to the working result; next state SHALL be IDLE, or ISSUE if start=1.
REQ-019 Latency: done SHALL assert exactly RES_W*(MULT_LAT+1)+1 rising edges after the edge that accepted start (289 at defaults, within the 600-cycle budget).
REQ-020 result SHALL hold its value from DONE until the next DONE; it SHALL NOT change during a computation.
REQ-021 start while busy SHALL abort the current computation:
- no done for the aborted operand;
- latency restarts from the new accept edge;
- in-flight multiplier products from the aborted operand SHALL be ignored.
REQ-022 start=1 in IDLE with an unchanged value SHALL recompute and pulse done again.
REQ-023 Comparisons SHALL be unsigned, on the full 2*RES_W bits; no overflow is possible since guess < 2^RES_W.
REQ-024 value=0 SHALL produce result=0; value=2^(2*RES_W)-1 SHALL produce result=2^RES_W-1.
REQ-025 Changes on value while busy SHALL have no effect.

Reset
REQ-026 While reset=0, the outputs SHALL be:
- result=0, done=0, busy=0;
- FSM in IDLE;
- index, WAIT counter and captured operand all 0.
REQ-027 reset=0 mid-computation SHALL abandon the operation; no done SHALL follow release until a new start.
REQ-028 start SHALL be ignored on the first rising edge on which reset is 0; the first edge after release SHALL accept start.

Verification
REQ-029 The bench SHALL cover these scenarios at defaults unless stated:
- start with value=1000000 -> done at edge 289, result=1000; busy high for edges 1..288.
- value=0 -> result=0; value=1 -> result=1; value=99 -> result=9; value=100 -> result=10.
- value=64'hFFFF_FFFF_FFFF_FFFF -> result=32'hFFFF_FFFF; value=64'hFFFF_FFFE_0000_0001 -> result=32'hFFFF_FFFF; value=64'hFFFF_FFFE_0000_0000 -> result=32'hFFFF_FFFE.
- start value=400, then start value=81 at edge 50 -> no done for 400; done at edge 50+289, result=9.
- reset=0 at edge 100 of a computation -> result=0, busy=0 immediately, no done; after release, start value=16 -> result=4.
- RES_W=8, MULT_LAT=2: value=65535 -> result=255, done at edge 25; plus 500 random operands vs. a floor-sqrt model.

Source files
------------

// File: rtl/isqrt_seq.sv
// Sequential integer square root: one result bit per trial, MSB first, using
// an internal pipelined squaring multiplier to test each candidate guess.
module isqrt_seq #(
    parameter int RES_W    = 32,
    parameter int MULT_LAT = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [2*RES_W-1:0] value,
    output logic [RES_W-1:0]   result,
    output logic               done,
    output logic               busy
);

    localparam int OP_W  = 2 * RES_W;
    localparam int IDX_W = $clog2(RES_W);
    localparam int CNT_W = 5;

    localparam logic [IDX_W-1:0] IDX_TOP   = IDX_W'(RES_W - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = (MULT_LAT > 1) ? CNT_W'(MULT_LAT - 2) : '0;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]       state_q,   state_d;
    logic [OP_W-1:0]  operand_q, operand_d;
    logic [RES_W-1:0] work_q,    work_d;
    logic [IDX_W-1:0] idx_q,     idx_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [RES_W-1:0] result_q,  result_d;
    logic             done_q,    done_d;

    logic [RES_W-1:0]    trialBit;
    logic [RES_W-1:0]    guess;
    logic                issueFire;
    logic [OP_W-1:0]     prodPipe_q [MULT_LAT];
    logic [MULT_LAT-1:0] prodVld_q,  prodVld_d;
    logic [OP_W-1:0]     prodTop;
    logic                prodVld;
    logic                guessFits;

    always_comb begin
        trialBit        = '0;
        trialBit[idx_q] = 1'b1;
        guess           = work_q | trialBit;
    end

    // A start in ISSUE aborts, so that cycle's guess must not enter the pipe as valid.
    assign issueFire = (state_q == S_ISSUE) && !start;

    // Every accepted start flushes the valid tags, so products of an aborted operand are dropped.
    always_comb begin
        prodVld_d = '0;
        if (!start) begin
            prodVld_d[0] = issueFire;
            for (int i = 1; i < MULT_LAT; i++) begin
                prodVld_d[i] = prodVld_q[i-1];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MULT_LAT; i++) begin
                prodPipe_q[i] <= '0;
            end
            prodVld_q <= '0;
        end else begin
            if (issueFire) begin
                prodPipe_q[0] <= OP_W'(guess) * OP_W'(guess);
            end
            for (int i = 1; i < MULT_LAT; i++) begin
                prodPipe_q[i] <= prodPipe_q[i-1];
            end
            prodVld_q <= prodVld_d;
        end
    end

    assign prodTop   = prodPipe_q[MULT_LAT-1];
    assign prodVld   = prodVld_q[MULT_LAT-1];
    assign guessFits = prodVld && (prodTop <= operand_q);

    // Results are published from DONE even when a new start arrives in that same cycle.
    always_comb begin
        state_d   = state_q;
        operand_d = operand_q;
        work_d    = work_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        done_d    = 1'b0;

        if (state_q == S_DONE) begin
            result_d = work_q;
            done_d   = 1'b1;
        end

        if (start) begin
            operand_d = value;
            work_d    = '0;
            idx_d     = IDX_TOP;
            cnt_d     = '0;
            state_d   = S_ISSUE;
        end else begin
            case (state_q)
                S_ISSUE: begin
                    cnt_d   = '0;
                    state_d = (MULT_LAT > 1) ? S_WAIT : S_CHECK;
                end
                S_WAIT: begin
                    if (cnt_q == WAIT_LAST) begin
                        state_d = S_CHECK;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_CHECK: begin
                    if (guessFits) begin
                        work_d = work_q | trialBit;
                    end
                    if (idx_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q - IDX_W'(1);
                        state_d = S_ISSUE;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            operand_q <= '0;
            work_q    <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            operand_q <= operand_d;
            work_q    <= work_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            done_q    <= done_d;
        end
    end

    assign result = result_q;
    assign done   = done_q;
    assign busy   = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_CHECK);

endmodule
